// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if
//   Command/byte result bundle from the UART command receiver to its consumer
//   (the VNA port switcher and any byte-level observer).
//   master : driven by uart_cmd_rx
//   slave  : consumer side
// Signals:
//   new_state         [1:0] last committed command code, held between commands
//   new_state_arrived       one-cycle strobe, new_state freshly committed
//   rx_byte           [7:0] last correctly framed byte
//   rx_valid                one-cycle strobe when rx_byte updates
//   frame_err               one-cycle strobe, stop bit sampled low
//   cmd_err                 one-cycle strobe, byte is not a command/terminator
interface uart_cmd_rx_if;
    logic [1:0] new_state;
    logic       new_state_arrived;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_err;

    modport master (
        output new_state, new_state_arrived, rx_byte, rx_valid, frame_err, cmd_err
    );
    modport slave (
        input  new_state, new_state_arrived, rx_byte, rx_valid, frame_err, cmd_err
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
//   8N1 UART receiver plus single-character command parser. Commands '0'/'1'/'2'
//   select a fixed port, 'A'/'a' requests auto-cycling (code 3); a CR or LF
//   commits the pending command to new_state with a one-cycle strobe.
// Ports:
//   Clk      system clock, rising edge
//   Rst_n    asynchronous active-low reset
//   UART_RX  asynchronous serial line, idles high
//   cmd      uart_cmd_rx_if.master: new_state, strobes, rx_byte
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          UART_RX,
    uart_cmd_rx_if.master cmd
);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rxs_q, rxs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             cmd_err_q, cmd_err_d;
    logic             pend_q, pend_d;
    logic [1:0]       pend_code_q, pend_code_d;
    logic [1:0]       new_state_q, new_state_d;
    logic             nsa_q, nsa_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;   // line idles high; avoid a false start at release
            rxs_q       <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_code_q <= '0;
            new_state_q <= '0;
            nsa_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            cmd_err_q   <= cmd_err_d;
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
            new_state_q <= new_state_d;
            nsa_q       <= nsa_d;
        end
    end

    // Receiver: synchroniser, bit timer and frame FSM
    always_comb begin
        rx_meta_d   = UART_RX;
        rxs_d       = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    if (!rxs_q) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;   // glitch shorter than half a bit
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == FULL) begin
                    shreg_d   = {rxs_q, shreg_q[7:1]};   // LSB first
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        rx_byte_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before another start is armed
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Parser: acts on the registered byte one cycle after rx_valid
    always_comb begin
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        new_state_d = new_state_q;
        nsa_d       = 1'b0;
        cmd_err_d   = 1'b0;
        if (frame_err_q) begin
            pend_d = 1'b0;
        end else if (rx_valid_q) begin
            case (rx_byte_q)
                8'h30, 8'h31, 8'h32: begin
                    pend_code_d = rx_byte_q[1:0];
                    pend_d      = 1'b1;
                end
                8'h41, 8'h61: begin
                    pend_code_d = 2'd3;
                    pend_d      = 1'b1;
                end
                8'h0D, 8'h0A: begin
                    // Terminator with nothing pending is dropped so CRLF commits once
                    if (pend_q) begin
                        new_state_d = pend_code_q;
                        nsa_d       = 1'b1;
                        pend_d      = 1'b0;
                    end
                end
                default: begin
                    cmd_err_d = 1'b1;
                    pend_d    = 1'b0;
                end
            endcase
        end
    end

    assign cmd.new_state         = new_state_q;
    assign cmd.new_state_arrived = nsa_q;
    assign cmd.rx_byte           = rx_byte_q;
    assign cmd.rx_valid          = rx_valid_q;
    assign cmd.frame_err         = frame_err_q;
    assign cmd.cmd_err           = cmd_err_q;
endmodule
